// File: rtl/seq_alu_pkg.sv
// Shared encodings, state type and helpers for the sequential ALU.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic {
        M_MUL = 1'b0,
        M_DIV = 1'b1
    } iter_mode_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
        logic err;
    } flags_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath: shift-add multiply and restoring unsigned divide,
// one step per cycle over a shared 2*WIDTH accumulator.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               run_q, run_d;
    iter_mode_e         mode_q, mode_d;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;

    // Accumulator: high half is partial product / remainder, low half holds
    // the multiplier / dividend bits still to be consumed.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, opnd_q};
        if (mode_q == M_MUL) begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
        end

        done   = run_q && (cnt_q == CNT_W'(1));
        acc_d  = acc_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        mode_d = mode_q;
        if (start) begin
            acc_d  = {{WIDTH{1'b0}}, a};
            opnd_d = b;
            cnt_d  = CNT_W'(WIDTH);
            run_d  = 1'b1;
            mode_d = mode ? M_DIV : M_MUL;
        end else if (run_q) begin
            acc_d = acc_step;
            cnt_d = cnt_q - CNT_W'(1);
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            mode_q <= M_MUL;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            mode_q <= mode_d;
        end
    end

    // Outputs show the accumulator after the in-flight step, so the final
    // value is available on the same edge that completes it.
    assign product_lo = acc_step[WIDTH-1:0];
    assign quotient   = acc_step[WIDTH-1:0];
    assign remainder  = acc_step[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops resolve on acceptance, MUL/DIVU/REMU
// run through seq_alu_iter; result and flags are registered together.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_f,
    output logic             neg_f,
    output logic             carry_f,
    output logic             ovf_f,
    output logic             err_f,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;

    logic             accept, iter_done;
    logic [WIDTH-1:0] prod_lo, quot, rem, fin_res;
    logic [WIDTH:0]   add_w, sub_w;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_e;

    assign accept = in_valid && (state_q == S_IDLE);

    seq_alu_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (accept && is_multicycle(op)),
        .mode       (op != OP_MUL),
        .a          (a),
        .b          (b),
        .done       (iter_done),
        .product_lo (prod_lo),
        .quotient   (quot),
        .remainder  (rem)
    );

    always_comb begin
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} - {1'b0, b};
        shamt   = b[SH_W-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_e   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = !sub_w[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_XOR:   alu_res = a ^ b;
            OP_SLL:   alu_res = a << shamt;
            OP_SRL:   alu_res = a >> shamt;
            OP_SRA:   alu_res = $unsigned($signed(a) >>> shamt);
            OP_SLT:   alu_res[0] = $signed(a) < $signed(b);
            OP_SLTU:  alu_res[0] = a < b;
            OP_PASSB: alu_res = b;
            OP_MUL, OP_DIVU, OP_REMU: alu_res = '0;
            default:  alu_e = 1'b1;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_MUL:  fin_res = prod_lo;
            OP_DIVU: fin_res = quot;
            default: fin_res = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dz_d     = dz_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = op;
                    dz_d = (b == '0) && (op != OP_MUL);
                    if (is_multicycle(op)) begin
                        state_d = S_BUSY;
                    end else begin
                        state_d       = S_DONE;
                        result_d      = alu_res;
                        flags_d.zero  = (alu_res == '0);
                        flags_d.neg   = alu_res[WIDTH-1];
                        flags_d.carry = alu_c;
                        flags_d.ovf   = alu_v;
                        flags_d.err   = alu_e;
                    end
                end
            end
            S_BUSY: begin
                if (iter_done) begin
                    state_d       = S_DONE;
                    result_d      = fin_res;
                    flags_d.zero  = (fin_res == '0);
                    flags_d.neg   = fin_res[WIDTH-1];
                    flags_d.carry = 1'b0;
                    flags_d.ovf   = 1'b0;
                    flags_d.err   = dz_q;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            dz_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dz_q     <= dz_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign zero_f    = flags_q.zero;
    assign neg_f     = flags_q.neg;
    assign carry_f   = flags_q.carry;
    assign ovf_f     = flags_q.ovf;
    assign err_f     = flags_q.err;

endmodule
